// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer:
// privilege modes, CSR bit positions, exception codes and FSM states.
package trap_ctrl_pkg;

  // Privilege modes (mode::mode_t in the wider codebase)
  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } mode_t;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mip / mie bit positions
  localparam int MIP_MSI = 3;
  localparam int MIP_MTI = 7;
  localparam int MIP_MEI = 11;

  // Interrupt cause codes equal their mip bit positions
  localparam logic [5:0] IRQ_CODE_MSI = 6'd3;
  localparam logic [5:0] IRQ_CODE_MTI = 6'd7;
  localparam logic [5:0] IRQ_CODE_MEI = 6'd11;

  // Synchronous exception codes reported at commit
  typedef enum logic [5:0] {
    EXC_INSTR_MISALIGNED = 6'd0,
    EXC_INSTR_FAULT      = 6'd1,
    EXC_ILLEGAL_INSTR    = 6'd2,
    EXC_BREAKPOINT       = 6'd3,
    EXC_LOAD_MISALIGNED  = 6'd4,
    EXC_LOAD_FAULT       = 6'd5,
    EXC_STORE_MISALIGNED = 6'd6,
    EXC_STORE_FAULT      = 6'd7,
    EXC_ECALL_U          = 6'd8,
    EXC_ECALL_S          = 6'd9,
    EXC_ECALL_M          = 6'd11,
    EXC_INSTR_PAGE_FAULT = 6'd12,
    EXC_LOAD_PAGE_FAULT  = 6'd13,
    EXC_STORE_PAGE_FAULT = 6'd15
  } sync_codes_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAVE  = 2'd1,
    ENTER = 2'd2,
    RET   = 2'd3
  } trap_state_t;

  // Only mode 1 is vectored; reserved modes 2 and 3 fall back to direct
  function automatic logic mtvec_vectored(input logic [1:0] mtvec_mode);
    return mtvec_mode == 2'b01;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// Fixed-priority encoder over enabled pending interrupts: MEI > MSI > MTI.
module trap_ctrl_irq_prio
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pend,
  output logic            any,
  output logic [5:0]      code
);

  // Only three machine-level sources exist; the remaining bits are ignored
  logic unused_pend;
  assign unused_pend = ^{pend[XLEN-1:MIP_MEI+1], pend[MIP_MEI-1:MIP_MTI+1],
                         pend[MIP_MTI-1:MIP_MSI+1], pend[MIP_MSI-1:0]};

  always_comb begin
    any  = 1'b1;
    code = '0;
    if (pend[MIP_MEI]) begin
      code = IRQ_CODE_MEI;
    end else if (pend[MIP_MSI]) begin
      code = IRQ_CODE_MSI;
    end else if (pend[MIP_MTI]) begin
      code = IRQ_CODE_MTI;
    end else begin
      any = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and MRET,
// sequences the CSR save/restore writes and redirects fetch.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int    XLEN       = 32,
  parameter mode_t RESET_PRIV = PRIV_M
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_valid_i,
  input  sync_codes_t       exc_code_i,
  input  logic [XLEN-1:0]   exc_pc_i,
  input  logic [XLEN-1:0]   exc_tval_i,
  input  logic              commit_valid_i,
  input  logic              mret_i,
  input  logic              meip_i,
  input  logic              msip_i,
  input  logic              mtip_i,
  input  logic [XLEN-1:0]   mstatus_i,
  input  logic [XLEN-1:0]   mie_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  output logic              busy_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              mepc_we_o,
  output logic              mcause_we_o,
  output logic              mtval_we_o,
  output logic              mstatus_we_o,
  output logic [XLEN-1:0]   mepc_wd_o,
  output logic [XLEN-1:0]   mcause_wd_o,
  output logic [XLEN-1:0]   mtval_wd_o,
  output logic [XLEN-1:0]   mstatus_wd_o,
  output logic [XLEN-1:0]   mip_o,
  output mode_t             priv_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  trap_state_t       state_q, state_d;
  logic [5:0]        cause_q, cause_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic              is_irq_q, is_irq_d;
  mode_t             priv_q, priv_d;

  logic [XLEN-1:0]   pend;
  logic              irq_any;
  logic [5:0]        irq_code;
  logic              take_irq;
  logic              take_trap;
  logic              take_mret;
  logic [XLEN-1:0]   vec_offset;

  always_comb begin
    mip_o          = '0;
    mip_o[MIP_MEI] = meip_i;
    mip_o[MIP_MTI] = mtip_i;
    mip_o[MIP_MSI] = msip_i;
  end

  assign pend = mip_o & mie_i;

  trap_ctrl_irq_prio #(.XLEN(XLEN)) u_irq_prio (
    .pend (pend),
    .any  (irq_any),
    .code (irq_code)
  );

  // An interrupt preempts the committing instruction, so its exception is moot
  assign take_irq  = commit_valid_i & mstatus_i[MSTATUS_MIE] & irq_any;
  assign take_trap = take_irq | exc_valid_i;
  assign take_mret = mret_i & ~take_trap;

  assign vec_offset = (mtvec_vectored(mtvec_i[1:0]) && is_irq_q)
                    ? XLEN'({cause_q, 2'b00}) : '0;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    pc_d             = pc_q;
    tval_d           = tval_q;
    is_irq_d         = is_irq_q;
    priv_d           = priv_q;
    busy_o           = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    mepc_we_o        = 1'b0;
    mcause_we_o      = 1'b0;
    mtval_we_o       = 1'b0;
    mstatus_we_o     = 1'b0;
    mepc_wd_o        = '0;
    mcause_wd_o      = '0;
    mtval_wd_o       = '0;
    mstatus_wd_o     = '0;

    unique case (state_q)
      IDLE: begin
        if (take_trap) begin
          busy_o   = 1'b1;
          state_d  = SAVE;
          is_irq_d = take_irq;
          cause_d  = take_irq ? irq_code : 6'(exc_code_i);
          pc_d     = exc_pc_i;
          tval_d   = take_irq ? '0 : exc_tval_i;
        end else if (take_mret) begin
          busy_o  = 1'b1;
          state_d = RET;
        end
      end

      SAVE: begin
        busy_o      = 1'b1;
        flush_o     = 1'b1;
        mepc_we_o   = 1'b1;
        mcause_we_o = 1'b1;
        mtval_we_o  = 1'b1;
        mepc_wd_o   = pc_q & ALIGN_MASK;
        mcause_wd_o = {is_irq_q, {(XLEN-7){1'b0}}, cause_q};
        mtval_wd_o  = tval_q;
        state_d     = ENTER;
      end

      ENTER: begin
        busy_o                                     = 1'b1;
        mstatus_we_o                               = 1'b1;
        mstatus_wd_o                               = mstatus_i;
        mstatus_wd_o[MSTATUS_MPIE]                 = mstatus_i[MSTATUS_MIE];
        mstatus_wd_o[MSTATUS_MIE]                  = 1'b0;
        mstatus_wd_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_q;
        priv_d                                     = PRIV_M;
        redirect_valid_o                           = 1'b1;
        // Wraps modulo 2^XLEN by construction
        redirect_pc_o                              = (mtvec_i & ALIGN_MASK) + vec_offset;
        state_d                                    = IDLE;
      end

      RET: begin
        busy_o                                     = 1'b1;
        flush_o                                    = 1'b1;
        mstatus_we_o                               = 1'b1;
        mstatus_wd_o                               = mstatus_i;
        mstatus_wd_o[MSTATUS_MIE]                  = mstatus_i[MSTATUS_MPIE];
        mstatus_wd_o[MSTATUS_MPIE]                 = 1'b1;
        mstatus_wd_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
        priv_d                                     = mode_t'(mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
        redirect_valid_o                           = 1'b1;
        redirect_pc_o                              = mepc_i;
        state_d                                    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state, so an async reset mid-sequence drops every strobe at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cause_q  <= '0;
      pc_q     <= '0;
      tval_q   <= '0;
      is_irq_q <= 1'b0;
      priv_q   <= RESET_PRIV;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cause_q  <= cause_d;
      pc_q     <= pc_d;
      tval_q   <= tval_d;
      is_irq_q <= is_irq_d;
      priv_q   <= priv_d;
    end
  end

  assign priv_o = priv_q;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap sequencer for the core's CSR file. Arbitrates between synchronous exceptions reported at commit and pending external, software and timer interrupts. On a trap it flushes the pipeline, writes mepc, mcause, mtval and mstatus in order, and redirects fetch to the mtvec target. It also sequences MRET: restores mstatus and privilege, then redirects to mepc.

Parameters:
XLEN, 32, datapath and CSR width
RESET_PRIV, 2'b11 (mode::M), privilege mode after reset

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
exc_valid_i  in  1  commit-stage instruction raises an exception
exc_code_i  in  6  exception::sync_codes_t
exc_pc_i  in  XLEN  PC of the committing/faulting instruction
exc_tval_i  in  XLEN  fault address or instruction bits
commit_valid_i  in  1  a valid instruction is at commit (interrupt boundary)
mret_i  in  1  committing instruction is MRET
meip_i / msip_i / mtip_i  in  1 each  raw interrupt lines
mstatus_i, mie_i, mtvec_i, mepc_i  in  XLEN each  current CSR values
busy_o  out  1  stall fetch and commit while high
flush_o  out  1  kill all in-flight instructions
redirect_valid_o  out  1  one-cycle fetch redirect
redirect_pc_o  out  XLEN  redirect target
mepc_we_o, mcause_we_o, mtval_we_o, mstatus_we_o  out  1 each  CSR write strobes
mepc_wd_o, mcause_wd_o, mtval_wd_o, mstatus_wd_o  out  XLEN each  CSR write data
mip_o  out  XLEN  live mip image: bit 11 = meip, bit 7 = mtip, bit 3 = msip
priv_o  out  2  current privilege (mode::mode_t)

Behaviour:
- Reset values: state IDLE; all strobes, busy_o, flush_o and redirect_valid_o are 0; all data outputs are 0; priv_o = RESET_PRIV.
- Interrupt take condition: pend = mip_o & mie_i; take_irq = commit_valid_i & mstatus_i[3] & |pend[11,7,3].
- Interrupt priority: MEI (11) > MSI (3) > MTI (7).
- Arbitration in IDLE:
  - take_irq beats exc_valid_i on the same instruction; the exception is dropped, since the instruction did not commit.
  - exc_valid_i beats mret_i.
  - mret_i is honoured only when exc_valid_i = 0 and take_irq = 0.
- FSM states: IDLE, SAVE, ENTER, RET.
  - IDLE -> SAVE on trap. Latch cause, exc_pc_i, tval (0 for interrupts) and is_irq. busy_o rises in the same cycle (combinational from the take decision).
  - SAVE (1 cycle): flush_o = 1. mepc_we_o, mcause_we_o and mtval_we_o pulse together.
    - mepc_wd = {pc[XLEN-1:2], 2'b00}.
    - mcause_wd = {is_irq, zero-extended code}; `CAUSE_INTERRUPT is ORed in for interrupts.
    - -> ENTER.
  - ENTER (1 cycle): mstatus_we_o = 1, with wdata = mstatus_i except MPIE[7] = MIE[3], MIE[3] = 0, MPP[12:11] = priv_o.
    - priv_o <= M. redirect_valid_o = 1.
    - redirect_pc_o = {mtvec_i[XLEN-1:2], 2'b00}. If mtvec_i[1:0] == 1 and is_irq, add 4*code.
    - -> IDLE.
  - IDLE -> RET on MRET: busy_o = 1 that cycle.
  - RET (1 cycle): flush_o = 1. mstatus_we_o = 1, with MIE = MPIE, MPIE = 1, MPP = U.
    - priv_o <= old MPP.
    - redirect_valid_o = 1, redirect_pc_o = mepc_i.
    - -> IDLE.
- Latency:
  - trap: decision cycle, then CSR save, then redirect in the 2nd cycle after the decision.
  - MRET: redirect in the 1st cycle after the decision.
- Inputs exc_valid_i, mret_i and interrupts are ignored in SAVE, ENTER and RET. The pipeline is stalled, so nothing is lost. An interrupt still pending afterwards is taken on the next commit_valid_i.
- mtvec_i[1:0] in {2,3} (reserved) is treated as direct mode.
- Vector target arithmetic wraps modulo 2^XLEN; no overflow flag.
- Reset asserted mid-sequence: FSM goes to IDLE immediately, with no partial CSR writes after reset deasserts. Strobes drop asynchronously.
- mip_o is combinational from the raw lines and is not latched.

Decomposition:
- Add to package csr: mstatus bit-position constants (MIE = 3, MPIE = 7, MPP = 12:11) and mip/mie bit positions (MSI = 3, MTI = 7, MEI = 11).
- Add to package exception: typedef trap_state_t {IDLE, SAVE, ENTER, RET}.
- Reuse mode::mode_t for priv_o.
- One sub-module: irq_prio. It is a combinational priority encoder from pend to {any, code[5:0]}.

Test Plan:
- Illegal instruction: exc_valid_i with code 2, pc 0x100, tval 0xDEADBEEF, mtvec 0x200 -> writes mepc = 0x100, mcause = 0x2, mtval = 0xDEADBEEF; the ENTER cycle shows MIE 1->0, MPIE = 1, MPP = 3; redirect 0x200 two cycles after the decision.
- Vectored timer interrupt: mtip_i = 1, mie bit 7 = 1, mstatus.MIE = 1, mtvec 0x201, commit_valid_i = 1 -> mcause = 0x80000007, mtval = 0, redirect 0x21C.
- Simultaneous events: meip, msip and an exception code 5 in the same cycle -> mcause = 0x8000000B; the exception is not recorded.
- Masked interrupt: meip with mstatus.MIE = 0 -> no trap, busy_o = 0, mip_o = 0x800.
- MRET: mepc 0x104, MPIE = 1, MPP = 0 -> redirect 0x104 one cycle after the decision; mstatus MIE = 1, MPIE = 1; priv_o = U.
- Reset mid-trap: assert rst during SAVE -> all strobes 0 in the same cycle; after release, state is IDLE, priv_o = M, and no mstatus write occurs.
